// File: rtl/arch_reg_file_pkg.sv
// Shared definitions for the architectural register file slice.
//   REG_WIDTH : architectural register index width (2**REG_WIDTH registers)
//   ROB_WIDTH : reorder-buffer tag width
//   cdb_t     : operand/broadcast bundle {valid, tag, data}
package arch_reg_file_pkg;
  localparam int REG_WIDTH  = 4;
  localparam int ROB_WIDTH  = 3;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 2 ** REG_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;
endpackage

// File: rtl/arch_reg_file_if.sv
// req_if: valid/ready handshake. A transfer happens on a cycle where both
// are high.
//   master : drives valid, samples ready
//   slave  : samples valid, drives ready
interface req_if;
  logic valid;
  logic ready;

  modport master (output valid, input ready);
  modport slave  (input valid, output ready);
endinterface

// File: rtl/arch_reg_file_reg_entry.sv
// reg_entry: state for one architectural register (data, pending, tag) and
// the update priority between flush, rename and commit.
//   clk, reset      : clock, async active-high reset
//   flush           : clear pending, ignore rename
//   commit_hit      : a commit targets this register this cycle
//   commit_tag/data : head ROB entry tag and result
//   rename_hit      : an issuing instruction targets this register
//   issue_tag       : ROB slot of the issuing instruction
//   data/pending/tag: current state
module reg_entry
  import arch_reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  commit_hit,
  input  logic [ROB_WIDTH-1:0]  commit_tag,
  input  logic [DATA_WIDTH-1:0] commit_data,
  input  logic                  rename_hit,
  input  logic [ROB_WIDTH-1:0]  issue_tag,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  pending,
  output logic [ROB_WIDTH-1:0]  tag
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data    <= '0;
      pending <= 1'b0;
      tag     <= '0;
    end else begin
      // Committed result always lands, even if a later producer is in flight.
      if (commit_hit) data <= commit_data;

      if (flush) begin
        pending <= 1'b0;
      end else if (rename_hit) begin
        // A same-cycle rename outranks the commit's pending clear.
        pending <= 1'b1;
        tag     <= issue_tag;
      end else if (commit_hit && (tag == commit_tag)) begin
        // Only the latest producer may clear pending.
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arch_reg_file.sv
// arch_reg_file: architectural register file with per-register rename tags.
//   clk, reset      : clock, async active-high reset
//   read_num        : N_READ operand register indices
//   arch_read       : N_READ results; valid=1 -> data, valid=0 -> pending tag
//   issue, issue_writes, issue_arch_num, issue_tag : destination rename
//   commit_req      : drives valid (!reset && !flush), samples ready
//   commit_arch_num, commit_tag, commit_data       : head ROB entry
//   flush           : clear all pending; ROB resets in the same cycle
module arch_reg_file
  import arch_reg_file_pkg::*;
#(
  parameter int N_READ = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_READ-1:0][REG_WIDTH-1:0]     read_num,
  output cdb_t [N_READ-1:0]                    arch_read,
  input  logic                                 issue,
  input  logic                                 issue_writes,
  input  logic [REG_WIDTH-1:0]                 issue_arch_num,
  input  logic [ROB_WIDTH-1:0]                 issue_tag,
  req_if.master                                commit_req,
  input  logic [REG_WIDTH-1:0]                 commit_arch_num,
  input  logic [ROB_WIDTH-1:0]                 commit_tag,
  input  logic [DATA_WIDTH-1:0]                commit_data,
  input  logic                                 flush
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_REGS-1:0]                 pending_q;
  logic [NUM_REGS-1:0][ROB_WIDTH-1:0]  tag_q;

  logic commit;
  logic rename;

  // Never stalls a commit; only reset and flush withhold it.
  assign commit_req.valid = !reset && !flush;
  assign commit           = commit_req.valid && commit_req.ready;
  assign rename           = issue && issue_writes && !flush;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .commit_hit  (commit && (commit_arch_num == REG_WIDTH'(g))),
      .commit_tag  (commit_tag),
      .commit_data (commit_data),
      .rename_hit  (rename && (issue_arch_num == REG_WIDTH'(g))),
      .issue_tag   (issue_tag),
      .data        (data_q[g]),
      .pending     (pending_q[g]),
      .tag         (tag_q[g])
    );
  end

  // Reads see pre-issue state; a commit matching the pending producer is
  // forwarded so dispatch does not wait an extra cycle.
  always_comb begin
    arch_read = '0;
    for (int i = 0; i < N_READ; i++) begin
      if (!pending_q[read_num[i]]) begin
        arch_read[i].valid = 1'b1;
        arch_read[i].data  = data_q[read_num[i]];
      end else if (commit && (commit_arch_num == read_num[i]) &&
                   (commit_tag == tag_q[read_num[i]])) begin
        arch_read[i].valid = 1'b1;
        arch_read[i].data  = commit_data;
      end else begin
        arch_read[i].valid = 1'b0;
        arch_read[i].tag   = tag_q[read_num[i]];
      end
    end
  end

endmodule

// File: tb/tb_arch_reg_file.sv
module tb_arch_reg_file;
  import arch_reg_file_pkg::*;

  localparam int N_READ = 2;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [N_READ-1:0][REG_WIDTH-1:0] read_num;
  cdb_t [N_READ-1:0]                arch_read;
  logic                             issue, issue_writes;
  logic [REG_WIDTH-1:0]             issue_arch_num;
  logic [ROB_WIDTH-1:0]             issue_tag;
  logic [REG_WIDTH-1:0]             commit_arch_num;
  logic [ROB_WIDTH-1:0]             commit_tag;
  logic [DATA_WIDTH-1:0]            commit_data;
  logic                             flush;

  int checks = 0;
  int errors = 0;

  req_if cif ();

  arch_reg_file #(.N_READ(N_READ)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_num        (read_num),
    .arch_read       (arch_read),
    .issue           (issue),
    .issue_writes    (issue_writes),
    .issue_arch_num  (issue_arch_num),
    .issue_tag       (issue_tag),
    .commit_req      (cif.master),
    .commit_arch_num (commit_arch_num),
    .commit_tag      (commit_tag),
    .commit_data     (commit_data),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input int r, input int t);
    issue = 1'b1; issue_writes = 1'b1;
    issue_arch_num = REG_WIDTH'(r); issue_tag = ROB_WIDTH'(t);
    tick();
    issue = 1'b0; issue_writes = 1'b0;
  endtask

  task automatic set_commit(input int r, input int t, input logic [31:0] d);
    cif.ready = 1'b1;
    commit_arch_num = REG_WIDTH'(r); commit_tag = ROB_WIDTH'(t); commit_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    read_num[0] = 4'd3; read_num[1] = 4'd3;
    #1;
    checks++;
    if (cif.valid !== 1'b0) begin
      errors++; $display("FAIL reset_commit_valid got %b want 0", cif.valid);
    end
    for (int i = 0; i < N_READ; i++) begin
      checks++;
      if (arch_read[i].valid !== 1'b1 || arch_read[i].data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read%0d got v=%b d=%h want v=1 d=0", i, arch_read[i].valid, arch_read[i].data);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cif.valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_commit_valid got %b want 1", cif.valid);
    end
    tick();
  endtask

  task automatic test_bypass();
    do_issue(5, 4);
    read_num[0] = 4'd5;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b0 || arch_read[0].tag !== 3'd4) begin
      errors++;
      $display("FAIL pend_r5 got v=%b t=%0d want v=0 t=4", arch_read[0].valid, arch_read[0].tag);
    end
    set_commit(5, 4, 32'hDEADBEEF);
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_r5 got v=%b d=%h want v=1 d=deadbeef", arch_read[0].valid, arch_read[0].data);
    end
    tick();
    cif.ready = 1'b0;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL commit_r5 got v=%b d=%h want v=1 d=deadbeef", arch_read[0].valid, arch_read[0].data);
    end
  endtask

  task automatic test_later_producer();
    do_issue(7, 2);
    do_issue(7, 3);
    read_num[1] = 4'd7;
    set_commit(7, 2, 32'h11);
    #1;
    checks++;
    if (arch_read[1].valid !== 1'b0 || arch_read[1].tag !== 3'd3) begin
      errors++;
      $display("FAIL stale_commit_same got v=%b t=%0d want v=0 t=3", arch_read[1].valid, arch_read[1].tag);
    end
    tick();
    cif.ready = 1'b0;
    #1;
    checks++;
    if (arch_read[1].valid !== 1'b0 || arch_read[1].tag !== 3'd3) begin
      errors++;
      $display("FAIL stale_commit_after got v=%b t=%0d want v=0 t=3", arch_read[1].valid, arch_read[1].tag);
    end
    set_commit(7, 3, 32'h22);
    tick();
    cif.ready = 1'b0;
    #1;
    checks++;
    if (arch_read[1].valid !== 1'b1 || arch_read[1].data !== 32'h22) begin
      errors++;
      $display("FAIL latest_commit_r7 got v=%b d=%h want v=1 d=22", arch_read[1].valid, arch_read[1].data);
    end
  endtask

  task automatic test_commit_rename();
    do_issue(9, 1);
    read_num[0] = 4'd9;
    set_commit(9, 1, 32'h55);
    issue = 1'b1; issue_writes = 1'b1; issue_arch_num = 4'd9; issue_tag = 3'd6;
    tick();
    issue = 1'b0; issue_writes = 1'b0; cif.ready = 1'b0;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b0 || arch_read[0].tag !== 3'd6) begin
      errors++;
      $display("FAIL rename_over_commit got v=%b t=%0d want v=0 t=6", arch_read[0].valid, arch_read[0].tag);
    end
    set_commit(9, 6, 32'h66);
    tick();
    cif.ready = 1'b0;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'h66) begin
      errors++;
      $display("FAIL r9_final got v=%b d=%h want v=1 d=66", arch_read[0].valid, arch_read[0].data);
    end
  endtask

  task automatic test_flush();
    // Seed committed values (pending=0, tag=0 so the clear condition holds).
    set_commit(1, 0, 32'hA1); tick();
    set_commit(2, 0, 32'hB2); tick();
    cif.ready = 1'b0;
    do_issue(1, 0);
    do_issue(2, 1);
    read_num[0] = 4'd1; read_num[1] = 4'd2;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b0 || arch_read[1].valid !== 1'b0 || arch_read[1].tag !== 3'd1) begin
      errors++;
      $display("FAIL pre_flush got v0=%b v1=%b t1=%0d want 0 0 1", arch_read[0].valid, arch_read[1].valid, arch_read[1].tag);
    end
    // Flush with a competing rename (r3) and a would-be commit of r1.
    flush = 1'b1;
    set_commit(1, 0, 32'hFF);
    issue = 1'b1; issue_writes = 1'b1; issue_arch_num = 4'd3; issue_tag = 3'd5;
    #1;
    checks++;
    if (cif.valid !== 1'b0) begin
      errors++; $display("FAIL flush_commit_valid got %b want 0", cif.valid);
    end
    checks++;
    if (arch_read[0].valid !== 1'b0 || arch_read[0].tag !== 3'd0) begin
      errors++;
      $display("FAIL flush_no_bypass got v=%b t=%0d want v=0 t=0", arch_read[0].valid, arch_read[0].tag);
    end
    tick();
    flush = 1'b0; cif.ready = 1'b0; issue = 1'b0; issue_writes = 1'b0;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'hA1 ||
        arch_read[1].valid !== 1'b1 || arch_read[1].data !== 32'hB2) begin
      errors++;
      $display("FAIL post_flush got v0=%b d0=%h v1=%b d1=%h want 1 a1 1 b2",
               arch_read[0].valid, arch_read[0].data, arch_read[1].valid, arch_read[1].data);
    end
    read_num[0] = 4'd3;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'h0) begin
      errors++;
      $display("FAIL flush_rename_ignored got v=%b d=%h want v=1 d=0", arch_read[0].valid, arch_read[0].data);
    end
  endtask

  task automatic test_async_reset();
    do_issue(4, 3);
    read_num[0] = 4'd4; read_num[1] = 4'd5;
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b0 || arch_read[1].data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pre_async got v0=%b d1=%h want 0 deadbeef", arch_read[0].valid, arch_read[1].data);
    end
    #1;
    reset = 1'b1;  // mid-cycle, no clock edge
    #1;
    checks++;
    if (arch_read[0].valid !== 1'b1 || arch_read[0].data !== 32'h0 ||
        arch_read[1].valid !== 1'b1 || arch_read[1].data !== 32'h0 || cif.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v0=%b d0=%h v1=%b d1=%h cv=%b want 1 0 1 0 0",
               arch_read[0].valid, arch_read[0].data, arch_read[1].valid, arch_read[1].data, cif.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    issue = 1'b0; issue_writes = 1'b0; issue_arch_num = '0; issue_tag = '0;
    cif.ready = 1'b0; commit_arch_num = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0; read_num = '0; reset = 1'b1;
    test_reset();
    test_bypass();
    test_later_producer();
    test_commit_rename();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_reg_file.md
Name: arch_reg_file

Overview:
- Architectural register file with a per-register rename tag. Sits on both sides of the reorder buffer: it answers operand reads, records the ROB tag of each issued destination, and retires ROB commits into architectural state.
- Operand reads return either committed data or the tag of the in-flight producer, packed as cdb_t. Dispatch uses the tag to fetch from the ROB or to wait on the CDB.
- It is the consumer on the ROB's commit req_if; this block drives commit_req.valid.

Parameters:
- N_READ, 2, number of operand read ports.
- Register count is 2**REG_WIDTH and tag width is ROB_WIDTH, both taken from the shared package (no local override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- read_num[N_READ]  in  REG_WIDTH each  architectural register to read
- arch_read[N_READ]  out  cdb_t each  .valid=1: .data is the committed value; .valid=0: .tag is the pending ROB tag, .data is don't-care
- issue  in  1  an instruction issues this cycle
- issue_writes  in  1  the issuing instruction has a destination register
- issue_arch_num  in  REG_WIDTH  destination register of the issuing instruction
- issue_tag  in  ROB_WIDTH  ROB slot allocated to the issuing instruction
- commit_req  req_if  -  this block drives .valid and samples .ready; a commit occurs when both are high
- commit_arch_num  in  REG_WIDTH  destination register of the head ROB entry
- commit_tag  in  ROB_WIDTH  tag of the head ROB entry
- commit_data  in  32  result of the head ROB entry
- flush  in  1  pipeline flush; the ROB is reset in the same cycle

Behaviour:
- State per register: data[31:0], pending (1 bit), tag[ROB_WIDTH-1:0].
- Reset (async): data=0, pending=0, tag=0 for every register. While reset is high, commit_req.valid=0 and all arch_read[i].valid=1 with data 0.
- commit_req.valid = !reset && !flush. This is combinational; the block never stalls a commit.
- commit = commit_req.valid && commit_req.ready.
- Read (combinational, zero latency), per port i, with r = read_num[i]:
  - pending[r]=0: valid=1, data=data[r].
  - pending[r]=1 and commit and commit_arch_num==r and commit_tag==tag[r]: bypass; valid=1, data=commit_data.
  - Otherwise: valid=0, tag=tag[r].
  - Reads show state before this cycle's issue. Same-cycle issue to r is not forwarded; dispatch handles intra-cycle dependence.
- Commit (posedge), when commit:
  - data[commit_arch_num] <= commit_data, unconditionally.
  - pending[commit_arch_num] <= 0, only if tag[commit_arch_num]==commit_tag and no rename of the same register this cycle. A later producer keeps the register pending.
- Rename (posedge), when issue && issue_writes:
  - pending[issue_arch_num] <= 1.
  - tag[issue_arch_num] <= issue_tag.
- Simultaneous commit and rename of the same register: data takes commit_data; pending stays 1; tag takes issue_tag. Rename has priority over commit's pending clear.
- Flush (sync, posedge):
  - All pending <= 0; data is retained.
  - Rename in the flush cycle is ignored.
  - No commit happens in the flush cycle, because valid=0.
- Tag wrap-around: tags are compared for full equality only. ROB depth guarantees no two live producers share a tag, so no age logic is needed.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Decomposition:
- Shared package (common.vh): REG_WIDTH, ROB_WIDTH, the cdb_t struct (valid, tag, data) and the req_if interface. These already exist; no new typedefs.
- One sub-module, reg_entry: holds one register's data, pending and tag, with the commit/rename/flush priority logic. It is instantiated 2**REG_WIDTH times via generate. The read mux and bypass stay in the top level.

Test Plan:
1. Reset, then read r3 on both ports -> valid=1, data=0; commit_req.valid=1 after reset drops.
2. Issue r5 with issue_tag=4; next cycle read r5 -> valid=0, tag=4. Then commit with r5, tag=4, data=0xDEADBEEF, ready=1:
   - Same-cycle read -> valid=1, data=0xDEADBEEF (bypass).
   - Following cycle -> pending=0, data=0xDEADBEEF.
3. Issue r7 with tag 2, then r7 with tag 3. Commit tag 2 with data 0x11 -> read r7 gives valid=0, tag=3. Commit tag 3 with data 0x22 -> valid=1, data=0x22.
4. Same cycle: commit r9 with tag 1 and data 0x55, and issue r9 with tag 6 -> next read r9 gives valid=0, tag=6; after commit of tag 6, data takes the new value.
5. Issue r1 with tag 0 and r2 with tag 1, then assert flush -> next cycle reads of r1 and r2 give valid=1 with the old committed data; commit_req.valid=0 during flush.
6. Assert reset asynchronously mid-stream with pending registers -> outputs return to reset values immediately, without waiting for clk.
